cpu_io_decoder: RTL and testbench
=================================

Name: cpu_io_decoder

Overview:
- Parametrised successor to the single `ioreq` flag carried on the CPU bus.
- Synchronises raw Z80 bus strobes into the clk28 domain and classifies each bus cycle as I/O, memory, interrupt-acknowledge or refresh.
- Matches I/O cycles against CHANNELS runtime-programmable port decoders and issues one-clock read/write strobes with latched address and data.
- Sits between the CPU pins and all peripheral port blocks (ULA ports, 7FFD/1FFD, AY, DivMMC, ...), replacing per-peripheral edge detection.

Parameters:
- CHANNELS, 4: number of port-match channels (1..16).
- ADDR_W, 16: width of the compared/latched address.
- SYNC_STAGES, 2: synchroniser depth on every strobe input (2..3).

Ports:
- clk28  in  1  system clock
- rst_n  in  1  synchronous reset, active-low
- bus_a  in  ADDR_W  CPU address
- bus_d  in  8  CPU data bus
- bus_iorq, bus_mreq, bus_m1, bus_rfsh, bus_rd, bus_wr  in  1 each  raw strobes, active-high
- match_val  in  CHANNELS*ADDR_W  per-channel port value, channel i at [i*ADDR_W +: ADDR_W]
- match_mask  in  CHANNELS*ADDR_W  per-channel mask; bit=1 means compare
- ch_en  in  CHANNELS  per-channel enable
- ioreq  out  1  one-clock pulse at the start of any non-INTACK I/O cycle
- io_rd_stb  out  CHANNELS  one-clock read strobe, at most one bit set
- io_wr_stb  out  CHANNELS  one-clock write strobe, at most one bit set
- io_hit  out  1  high for the whole I/O cycle while a channel matched
- io_addr  out  ADDR_W  address latched at cycle start
- io_wdata  out  8  data latched at the write strobe
- intack_stb  out  1  one-clock pulse at INTACK start
- m1_stb  out  1  one-clock pulse at opcode-fetch start (mreq&m1)
- rfsh_stb  out  1  one-clock pulse at refresh start (mreq&rfsh)
- cycle_end  out  1  one-clock pulse when iorq and mreq are both released

Behaviour:
- Reset (rst_n=0 at a clk28 edge):
  - All outputs 0; io_addr=0; io_wdata=0.
  - Synchroniser flops cleared; FSM in IDLE.
  - Reset mid-cycle abandons the cycle. After release the FSM ignores the in-flight cycle and waits until synchronised iorq=0 and mreq=0 before leaving IDLE.
- Synchronisation: every strobe passes SYNC_STAGES flops. Latency from raw edge to output strobe = SYNC_STAGES+1 clocks.
- Address/data capture: bus_a and bus_d are sampled directly, not synchronised; they are stable while the strobes are active.
- FSM states: IDLE, IO, IO_DONE, INTACK, MEM.
- IDLE:
  - s_iorq&!s_m1 -> IO. Pulse ioreq, latch io_addr, evaluate match.
  - s_iorq&s_m1 -> INTACK. Pulse intack_stb; no channel strobes.
  - s_mreq -> MEM. Pulse m1_stb if s_m1; pulse rfsh_stb if s_rfsh.
  - Simultaneous s_iorq and s_mreq: I/O takes priority.
- Channel match: hit_i = ch_en[i] & ((io_addr ^ val_i) & mask_i)==0. Lowest index wins; the winner index is registered on IO entry.
- IO:
  - First clock with s_rd=1 -> pulse io_rd_stb[winner].
  - First clock with s_wr=1 -> latch io_wdata=bus_d, pulse io_wr_stb[winner].
  - Either case then -> IO_DONE.
  - No hit -> no strobes, but ioreq and cycle_end still pulse.
  - io_hit is held from IO entry until return to IDLE.
- IO_DONE: further rd/wr activity is ignored, so there is exactly one strobe per cycle.
- Exit: from IO, IO_DONE, INTACK or MEM, when s_iorq=0 and s_mreq=0 -> IDLE with cycle_end pulsed. Back-to-back cycles need at least one idle sample.
- Mask of all zeros matches every port. A channel with ch_en=0 never matches.
- match_val, match_mask and ch_en are sampled only at IO entry; changes mid-cycle have no effect.

Decomposition:
- Add to package `common`:
  - typedef enum bus_state_t {BUS_IDLE, BUS_IO, BUS_IO_DONE, BUS_INTACK, BUS_MEM}.
  - localparam IO_CH_MAX = 16.
- Sub-module `sync_strobe` (parameter STAGES): single-bit synchroniser, synchronous active-low reset, instantiated once per strobe.
- Priority encoder as a function in the package.

Test Plan:
- Port write: ch0 val=16'h00FE mask=16'h00FF, bus_a=16'h7FFE, iorq+wr, d=8'h07 -> ioreq pulse at SYNC_STAGES+1; io_wr_stb=4'b0001 once; io_wdata=8'h07; cycle_end on release.
- Priority overlap: ch1 val=16'h7FFD mask=16'h8002, ch3 mask=0, read of 16'h7FFD -> io_rd_stb=4'b0010 only; with ch_en[1]=0 -> 4'b1000.
- INTACK: iorq+m1, bus_a=16'hFFFF -> intack_stb=1 once; ioreq=0; no channel strobes.
- Memory: mreq+m1+rd, then mreq+rfsh -> m1_stb then rfsh_stb, each one clock, each followed by cycle_end; ioreq stays 0.
- Reset mid-cycle: rst_n low for 1 clock during IO with wr held -> all outputs 0; no strobe until bus idles and a new cycle starts.
- Glitch/hold: wr toggled twice inside one IO cycle -> exactly one io_wr_stb; unmatched port 16'h1234 -> ioreq and cycle_end only.

Source files
------------

// File: rtl/cpu_io_decoder_pkg.sv
// Shared types and helpers for the CPU I/O decoder: bus-cycle states,
// channel limits and the channel priority encoder.
package common;

  localparam int IO_CH_MAX   = 16;
  localparam int IO_CH_IDX_W = 4;

  typedef enum logic [2:0] {
    BUS_IDLE    = 3'd0,
    BUS_IO      = 3'd1,
    BUS_IO_DONE = 3'd2,
    BUS_INTACK  = 3'd3,
    BUS_MEM     = 3'd4
  } bus_state_t;

  // Lowest set bit wins; returns 0 when nothing is set (caller qualifies with |req).
  function automatic logic [IO_CH_IDX_W-1:0] prio_enc(input logic [IO_CH_MAX-1:0] req);
    logic [IO_CH_IDX_W-1:0] idx;
    idx = '0;
    for (int i = IO_CH_MAX - 1; i >= 0; i--) begin
      if (req[i]) idx = IO_CH_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cpu_io_decoder_if.sv
// CPU-side bus, port-match configuration and decoded strobes of the I/O decoder.
interface cpu_io_decoder_if #(
  parameter int CHANNELS = 4,
  parameter int ADDR_W   = 16
);
  logic [ADDR_W-1:0]          bus_a;
  logic [7:0]                 bus_d;
  logic                       bus_iorq;
  logic                       bus_mreq;
  logic                       bus_m1;
  logic                       bus_rfsh;
  logic                       bus_rd;
  logic                       bus_wr;
  logic [CHANNELS*ADDR_W-1:0] match_val;
  logic [CHANNELS*ADDR_W-1:0] match_mask;
  logic [CHANNELS-1:0]        ch_en;

  logic                       ioreq;
  logic [CHANNELS-1:0]        io_rd_stb;
  logic [CHANNELS-1:0]        io_wr_stb;
  logic                       io_hit;
  logic [ADDR_W-1:0]          io_addr;
  logic [7:0]                 io_wdata;
  logic                       intack_stb;
  logic                       m1_stb;
  logic                       rfsh_stb;
  logic                       cycle_end;

  modport master (
    output bus_a, bus_d, bus_iorq, bus_mreq, bus_m1, bus_rfsh, bus_rd, bus_wr,
    output match_val, match_mask, ch_en,
    input  ioreq, io_rd_stb, io_wr_stb, io_hit, io_addr, io_wdata,
    input  intack_stb, m1_stb, rfsh_stb, cycle_end
  );

  modport slave (
    input  bus_a, bus_d, bus_iorq, bus_mreq, bus_m1, bus_rfsh, bus_rd, bus_wr,
    input  match_val, match_mask, ch_en,
    output ioreq, io_rd_stb, io_wr_stb, io_hit, io_addr, io_wdata,
    output intack_stb, m1_stb, rfsh_stb, cycle_end
  );

endinterface

// File: rtl/cpu_io_decoder_sync_strobe.sv
// Single-bit multi-flop synchroniser for a raw CPU strobe into the clk28 domain.
module sync_strobe #(
  parameter int STAGES = 2
) (
  input  logic clk28,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk28) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cpu_io_decoder.sv
// Classifies synchronised Z80 bus cycles and issues one-shot, channel-decoded
// I/O read/write strobes with latched address and write data.
module cpu_io_decoder
  import common::*;
#(
  parameter int CHANNELS    = 4,
  parameter int ADDR_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk28,
  input logic              rst_n,
  cpu_io_decoder_if.slave  bus
);

  logic [5:0] raw_stb;
  logic [5:0] sync_stb;
  logic       s_iorq, s_mreq, s_m1, s_rfsh, s_rd, s_wr;

  assign raw_stb = {bus.bus_iorq, bus.bus_mreq, bus.bus_m1,
                    bus.bus_rfsh, bus.bus_rd, bus.bus_wr};

  for (genvar g = 0; g < 6; g++) begin : g_sync
    sync_strobe #(.STAGES(SYNC_STAGES)) u_sync (
      .clk28 (clk28),
      .rst_n (rst_n),
      .d     (raw_stb[g]),
      .q     (sync_stb[g])
    );
  end

  assign {s_iorq, s_mreq, s_m1, s_rfsh, s_rd, s_wr} = sync_stb;

  bus_state_t               state_q, state_d;
  logic [1:0]               warm_q, warm_d;
  logic                     armed_q, armed_d;
  logic                     ioreq_q, ioreq_d;
  logic [CHANNELS-1:0]      rd_stb_q, rd_stb_d;
  logic [CHANNELS-1:0]      wr_stb_q, wr_stb_d;
  logic                     hit_q, hit_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [7:0]               wdata_q, wdata_d;
  logic [IO_CH_IDX_W-1:0]   win_q, win_d;
  logic                     intack_q, intack_d;
  logic                     m1_q, m1_d;
  logic                     rfsh_q, rfsh_d;
  logic                     end_q, end_d;

  logic [IO_CH_MAX-1:0]     hits;
  logic [CHANNELS-1:0]      win_onehot;
  logic                     bus_idle;

  always_comb begin
    hits = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hits[i] = bus.ch_en[i] &
                (((bus.bus_a ^ bus.match_val[i*ADDR_W +: ADDR_W]) &
                  bus.match_mask[i*ADDR_W +: ADDR_W]) == '0);
    end
  end

  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      win_onehot[i] = (win_q == IO_CH_IDX_W'(i));
    end
  end

  // The synchroniser outputs are meaningless until the pipeline has refilled
  // after reset; only an idle sample taken after that may arm the FSM, so a
  // cycle that was in flight across reset is never decoded.
  always_comb begin
    warm_d   = (warm_q != 2'd0) ? warm_q - 2'd1 : warm_q;
    armed_d  = armed_q | ((warm_q == 2'd0) & ~s_iorq & ~s_mreq);
    bus_idle = ~s_iorq & ~s_mreq;
  end

  always_comb begin
    state_d  = state_q;
    ioreq_d  = 1'b0;
    rd_stb_d = '0;
    wr_stb_d = '0;
    hit_d    = hit_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    win_d    = win_q;
    intack_d = 1'b0;
    m1_d     = 1'b0;
    rfsh_d   = 1'b0;
    end_d    = 1'b0;

    case (state_q)
      BUS_IDLE: begin
        if (armed_q) begin
          if (s_iorq && !s_m1) begin
            state_d = BUS_IO;
            ioreq_d = 1'b1;
            addr_d  = bus.bus_a;
            win_d   = prio_enc(hits);
            hit_d   = |hits;
          end else if (s_iorq) begin
            state_d  = BUS_INTACK;
            intack_d = 1'b1;
          end else if (s_mreq) begin
            state_d = BUS_MEM;
            m1_d    = s_m1;
            rfsh_d  = s_rfsh;
          end
        end
      end

      BUS_IO: begin
        if (bus_idle) begin
          state_d = BUS_IDLE;
          end_d   = 1'b1;
          hit_d   = 1'b0;
        end else if (s_rd) begin
          state_d  = BUS_IO_DONE;
          rd_stb_d = hit_q ? win_onehot : '0;
        end else if (s_wr) begin
          state_d  = BUS_IO_DONE;
          wdata_d  = bus.bus_d;
          wr_stb_d = hit_q ? win_onehot : '0;
        end
      end

      default: begin
        if (bus_idle) begin
          state_d = BUS_IDLE;
          end_d   = 1'b1;
          hit_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      state_q  <= BUS_IDLE;
      warm_q   <= 2'(SYNC_STAGES);
      armed_q  <= 1'b0;
      ioreq_q  <= 1'b0;
      rd_stb_q <= '0;
      wr_stb_q <= '0;
      hit_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      win_q    <= '0;
      intack_q <= 1'b0;
      m1_q     <= 1'b0;
      rfsh_q   <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      warm_q   <= warm_d;
      armed_q  <= armed_d;
      ioreq_q  <= ioreq_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
      hit_q    <= hit_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      win_q    <= win_d;
      intack_q <= intack_d;
      m1_q     <= m1_d;
      rfsh_q   <= rfsh_d;
      end_q    <= end_d;
    end
  end

  assign bus.ioreq      = ioreq_q;
  assign bus.io_rd_stb  = rd_stb_q;
  assign bus.io_wr_stb  = wr_stb_q;
  assign bus.io_hit     = hit_q;
  assign bus.io_addr    = addr_q;
  assign bus.io_wdata   = wdata_q;
  assign bus.intack_stb = intack_q;
  assign bus.m1_stb     = m1_q;
  assign bus.rfsh_stb   = rfsh_q;
  assign bus.cycle_end  = end_q;

endmodule

// File: tb/tb_cpu_io_decoder.sv
// Directed bench for cpu_io_decoder: vector table of I/O cycles plus
// hand-written INTACK, memory, reset and glitch sequences.
module tb_cpu_io_decoder;

  logic clk28 = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk28 = ~clk28;

  cpu_io_decoder_if #(.CHANNELS(4), .ADDR_W(16)) bus ();

  cpu_io_decoder #(.CHANNELS(4), .ADDR_W(16), .SYNC_STAGES(2)) dut (
    .clk28 (clk28),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  int n_ioreq, n_rd, n_wr, n_int, n_m1, n_rfsh, n_end, first_ioreq;
  logic [3:0] rd_or, wr_or;
  logic hit_seen;

  always @(posedge clk28) cyc++;

  always @(negedge clk28) begin
    if (bus.ioreq) begin
      n_ioreq++;
      if (first_ioreq < 0) first_ioreq = cyc;
    end
    if (bus.io_rd_stb != 4'b0) begin
      n_rd++;
      rd_or = rd_or | bus.io_rd_stb;
    end
    if (bus.io_wr_stb != 4'b0) begin
      n_wr++;
      wr_or = wr_or | bus.io_wr_stb;
    end
    if (bus.intack_stb) n_int++;
    if (bus.m1_stb)     n_m1++;
    if (bus.rfsh_stb)   n_rfsh++;
    if (bus.cycle_end)  n_end++;
    if (bus.io_hit)     hit_seen = 1'b1;
  end

  task automatic clear_mon();
    n_ioreq = 0; n_rd = 0; n_wr = 0; n_int = 0; n_m1 = 0; n_rfsh = 0; n_end = 0;
    first_ioreq = -1; rd_or = '0; wr_or = '0; hit_seen = 1'b0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {24'h0, bus.ioreq, bus.io_rd_stb, bus.io_wr_stb, bus.io_hit, bus.io_addr,
            bus.io_wdata, bus.intack_stb, bus.m1_stb, bus.rfsh_stb, bus.cycle_end};
  endfunction

  task automatic idle_bus();
    bus.bus_iorq = 1'b0; bus.bus_mreq = 1'b0; bus.bus_m1 = 1'b0;
    bus.bus_rfsh = 1'b0; bus.bus_rd = 1'b0; bus.bus_wr = 1'b0;
  endtask

  // Strobes at cycle 0, rd/wr one cycle later, held 7 cycles, then 6 idle cycles.
  task automatic run_cycle(input logic iorq, input logic mreq, input logic m1,
                           input logic rfsh, input logic rd, input logic wr,
                           input logic [15:0] a, input logic [7:0] d);
    @(posedge clk28); #2;
    clear_mon();
    bus.bus_a = a; bus.bus_d = d;
    bus.bus_iorq = iorq; bus.bus_mreq = mreq; bus.bus_m1 = m1; bus.bus_rfsh = rfsh;
    start_cyc = cyc;
    @(posedge clk28); #2;
    bus.bus_rd = rd; bus.bus_wr = wr;
    repeat (6) @(posedge clk28);
    #2 idle_bus();
    repeat (6) @(posedge clk28);
    #2;
  endtask

  typedef struct {
    string       name;
    logic [15:0] a;
    logic        is_wr;
    logic [7:0]  d;
    logic [3:0]  en;
    logic [3:0]  exp_rd;
    logic [3:0]  exp_wr;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{"wr_7ffe_ch0",  16'h7FFE, 1'b1, 8'h07, 4'b1111, 4'b0000, 4'b0001, 1'b1};
    vecs[1] = '{"rd_7ffd_ch1",  16'h7FFD, 1'b0, 8'h00, 4'b1111, 4'b0010, 4'b0000, 1'b1};
    vecs[2] = '{"rd_7ffd_ch3",  16'h7FFD, 1'b0, 8'h00, 4'b1101, 4'b1000, 4'b0000, 1'b1};
    vecs[3] = '{"wr_1ffd_ch2",  16'h1FFD, 1'b1, 8'hA5, 4'b1101, 4'b0000, 4'b0100, 1'b1};
    vecs[4] = '{"wr_1ffd_ch1",  16'h1FFD, 1'b1, 8'h3C, 4'b1111, 4'b0000, 4'b0010, 1'b1};
    vecs[5] = '{"rd_1234_miss", 16'h1234, 1'b0, 8'h00, 4'b0001, 4'b0000, 4'b0000, 1'b0};
    vecs[6] = '{"rd_1234_ch3",  16'h1234, 1'b0, 8'h00, 4'b1000, 4'b1000, 4'b0000, 1'b1};
    vecs[7] = '{"rd_00fe_off",  16'h00FE, 1'b0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[8] = '{"wr_80fe_ch0",  16'h80FE, 1'b1, 8'hFF, 4'b0011, 4'b0000, 4'b0001, 1'b1};
    vecs[9] = '{"rd_80fd_miss", 16'h80FD, 1'b0, 8'h00, 4'b0110, 4'b0000, 4'b0000, 1'b0};

    idle_bus();
    bus.bus_a = '0; bus.bus_d = '0;
    bus.match_val  = {16'h0000, 16'h1FFD, 16'h7FFD, 16'h00FE};
    bus.match_mask = {16'h0000, 16'hF002, 16'h8002, 16'h00FF};
    bus.ch_en = 4'b1111;
    clear_mon();

    repeat (3) @(posedge clk28);
    @(negedge clk28);
    chk("reset_outputs", all_outputs(), 64'h0);
    @(posedge clk28); #2 rst_n = 1'b1;
    repeat (4) @(posedge clk28);

    foreach (vecs[k]) begin
      bus.ch_en = vecs[k].en;
      run_cycle(1'b1, 1'b0, 1'b0, 1'b0, !vecs[k].is_wr, vecs[k].is_wr, vecs[k].a, vecs[k].d);
      chk({vecs[k].name, "_ioreq_cnt"}, 64'(n_ioreq), 64'd1);
      chk({vecs[k].name, "_latency"},   64'(first_ioreq - start_cyc), 64'd3);
      chk({vecs[k].name, "_rd_stb"},    64'(rd_or), 64'(vecs[k].exp_rd));
      chk({vecs[k].name, "_rd_cnt"},    64'(n_rd), 64'(vecs[k].exp_rd != 4'b0));
      chk({vecs[k].name, "_wr_stb"},    64'(wr_or), 64'(vecs[k].exp_wr));
      chk({vecs[k].name, "_wr_cnt"},    64'(n_wr), 64'(vecs[k].exp_wr != 4'b0));
      chk({vecs[k].name, "_hit"},       64'(hit_seen), 64'(vecs[k].exp_hit));
      chk({vecs[k].name, "_end_cnt"},   64'(n_end), 64'd1);
      chk({vecs[k].name, "_io_addr"},   64'(bus.io_addr), 64'(vecs[k].a));
      chk({vecs[k].name, "_hit_clr"},   64'(bus.io_hit), 64'd0);
      if (vecs[k].is_wr) chk({vecs[k].name, "_wdata"}, 64'(bus.io_wdata), 64'(vecs[k].d));
    end

    bus.ch_en = 4'b1111;
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 8'h00);
    chk("intack_cnt",       64'(n_int), 64'd1);
    chk("intack_ioreq",     64'(n_ioreq), 64'd0);
    chk("intack_strobes",   64'(n_rd + n_wr), 64'd0);
    chk("intack_end",       64'(n_end), 64'd1);

    run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0123, 8'h00);
    chk("mem_m1_cnt",       64'(n_m1), 64'd1);
    chk("mem_m1_rfsh",      64'(n_rfsh), 64'd0);
    chk("mem_m1_end",       64'(n_end), 64'd1);
    chk("mem_m1_ioreq",     64'(n_ioreq + n_rd), 64'd0);
    run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0040, 8'h00);
    chk("mem_rfsh_cnt",     64'(n_rfsh), 64'd1);
    chk("mem_rfsh_m1",      64'(n_m1), 64'd0);
    chk("mem_rfsh_end",     64'(n_end), 64'd1);
    chk("mem_rfsh_ioreq",   64'(n_ioreq), 64'd0);

    // Reset for one clock while an I/O write is in progress.
    bus.ch_en = 4'b0001;
    @(posedge clk28); #2;
    clear_mon();
    bus.bus_a = 16'h7FFE; bus.bus_d = 8'h5A; bus.bus_iorq = 1'b1;
    @(posedge clk28); #2 bus.bus_wr = 1'b1;
    @(posedge clk28); #2;
    @(posedge clk28); #2 rst_n = 1'b0;
    @(posedge clk28); #2 rst_n = 1'b1;
    @(negedge clk28);
    chk("rstmid_outputs", all_outputs(), 64'h0);
    @(posedge clk28); #2;
    clear_mon();
    repeat (10) @(posedge clk28);
    #2;
    chk("rstmid_no_ioreq", 64'(n_ioreq), 64'd0);
    chk("rstmid_no_wr",    64'(n_wr), 64'd0);
    chk("rstmid_no_end",   64'(n_end), 64'd0);
    chk("rstmid_no_hit",   64'(hit_seen), 64'd0);
    idle_bus();
    repeat (6) @(posedge clk28);
    run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h7FFE, 8'h5A);
    chk("rstmid_after_wr", 64'(wr_or), 64'h1);
    chk("rstmid_after_cnt", 64'(n_wr), 64'd1);
    chk("rstmid_after_data", 64'(bus.io_wdata), 64'h5A);

    // wr toggled twice in one I/O cycle; ch_en dropped after the cycle was entered.
    bus.ch_en = 4'b0001;
    @(posedge clk28); #2;
    clear_mon();
    bus.bus_a = 16'h7FFE; bus.bus_d = 8'h11; bus.bus_iorq = 1'b1;
    @(posedge clk28); #2 bus.bus_wr = 1'b1;
    @(posedge clk28); #2;
    @(posedge clk28); #2 bus.ch_en = 4'b0000;
    @(posedge clk28); #2 bus.bus_wr = 1'b0; bus.bus_d = 8'h22;
    repeat (3) @(posedge clk28);
    #2 bus.bus_wr = 1'b1;
    repeat (3) @(posedge clk28);
    #2 bus.bus_wr = 1'b0;
    repeat (2) @(posedge clk28);
    #2 idle_bus();
    repeat (6) @(posedge clk28);
    #2;
    chk("glitch_wr_cnt",  64'(n_wr), 64'd1);
    chk("glitch_wr_stb",  64'(wr_or), 64'h1);
    chk("glitch_wdata",   64'(bus.io_wdata), 64'h11);
    chk("glitch_ioreq",   64'(n_ioreq), 64'd1);
    chk("glitch_end",     64'(n_end), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
